// File: rtl/igmp_pkg.sv
// igmp_pkg: IGMP type codes, FSM state type and multicast range helpers shared by the group table.
package igmp_pkg;

    localparam logic [7:0] IGMP_QUERY     = 8'h11;
    localparam logic [7:0] IGMP_V1_REPORT = 8'h12;
    localparam logic [7:0] IGMP_V2_REPORT = 8'h16;
    localparam logic [7:0] IGMP_V3_REPORT = 8'h22;
    localparam logic [7:0] IGMP_LEAVE     = 8'h17;

    // 224.0.0.0/4
    localparam logic [31:0] MCAST_MASK = 32'hF000_0000;
    localparam logic [31:0] MCAST_BASE = 32'hE000_0000;

    typedef enum logic [1:0] {IDLE, MATCH, UPDATE, AGE} state_e;

    function automatic logic is_report(input logic [7:0] t);
        return t == IGMP_V1_REPORT || t == IGMP_V2_REPORT || t == IGMP_V3_REPORT;
    endfunction

    function automatic logic is_mcast(input logic [31:0] g);
        return (g & MCAST_MASK) == MCAST_BASE;
    endfunction

endpackage

// File: rtl/igmp_tick_gen.sv
// igmp_tick_gen: aging prescaler, one-cycle tick_o every TICK_DIV clk cycles.
//   clk    in  clock, rising edge
//   rst    in  asynchronous active-low reset
//   tick_o out single-cycle aging tick
module igmp_tick_gen #(
    parameter int TICK_DIV = 1000
) (
    input  logic clk,
    input  logic rst,
    output logic tick_o
);

    localparam int W = $clog2(TICK_DIV);

    logic [W-1:0] cnt_q, cnt_d;

    assign tick_o = cnt_q == W'(TICK_DIV - 1);
    assign cnt_d  = tick_o ? '0 : cnt_q + W'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

endmodule

// File: rtl/igmp_group_table.sv
// igmp_group_table: IGMP multicast membership table with aging timers and 1-cycle lookup.
//   clk, rst (async active-low)
//   in_valid/in_type/in_group  -> in_ready      parsed IGMP message in
//   lkp_req/lkp_group          -> lkp_valid/lkp_hit   lookup, result next cycle
//   count, full, drop_pulse, expire_pulse       table status
//   rpt_cnt/leave_cnt/query_cnt/drop_cnt        statistics, live only with IGMP_STATS_EN defined
module igmp_group_table
    import igmp_pkg::*;
#(
    parameter int ENTRIES  = 8,
    parameter int TIMER_W  = 8,
    parameter int GMI      = 255,
    parameter int LMQT     = 2,
    parameter int TICK_DIV = 1000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  logic [7:0]                   in_type,
    input  logic [31:0]                  in_group,
    output logic                         in_ready,
    input  logic                         lkp_req,
    input  logic [31:0]                  lkp_group,
    output logic                         lkp_valid,
    output logic                         lkp_hit,
    output logic [$clog2(ENTRIES+1)-1:0] count,
    output logic                         full,
    output logic                         drop_pulse,
    output logic                         expire_pulse,
    output logic [15:0]                  rpt_cnt,
    output logic [15:0]                  leave_cnt,
    output logic [15:0]                  query_cnt,
    output logic [15:0]                  drop_cnt
);

    localparam int CW = $clog2(ENTRIES + 1);
    localparam int IW = $clog2(ENTRIES);
    localparam logic [TIMER_W-1:0] GMI_T  = TIMER_W'(GMI);
    localparam logic [TIMER_W-1:0] LMQT_T = TIMER_W'(LMQT);

    state_e             state_q, state_d;
    logic [7:0]         type_q, type_d;
    logic [31:0]        group_q, group_d;
    logic               hit_q, hit_d, free_q, free_d;
    logic [IW-1:0]      hit_idx_q, hit_idx_d, free_idx_q, free_idx_d, idx_q, idx_d;
    logic               pend_q, pend_d;
    logic [ENTRIES-1:0] used_q, used_d;
    logic [31:0]        grp_q [ENTRIES];
    logic [31:0]        grp_d [ENTRIES];
    logic [TIMER_W-1:0] tmr_q [ENTRIES];
    logic [TIMER_W-1:0] tmr_d [ENTRIES];
    logic [CW-1:0]      count_q, count_d;
    logic               drop_q, drop_d, exp_q, exp_d;
    logic               lkp_valid_q, lkp_hit_q;
    logic               tick, m_hit, m_free, lkp_match;
    logic [IW-1:0]      m_hit_idx, m_free_idx;

    igmp_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk    (clk),
        .rst    (rst),
        .tick_o (tick)
    );

    // Descending scan so the lowest matching / lowest free index wins.
    always_comb begin
        m_hit      = 1'b0;
        m_free     = 1'b0;
        m_hit_idx  = '0;
        m_free_idx = '0;
        lkp_match  = 1'b0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (used_q[i] && grp_q[i] == group_q) begin
                m_hit     = 1'b1;
                m_hit_idx = IW'(i);
            end
            if (!used_q[i]) begin
                m_free     = 1'b1;
                m_free_idx = IW'(i);
            end
            if (used_q[i] && grp_q[i] == lkp_group) lkp_match = 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        type_d     = type_q;
        group_d    = group_q;
        hit_d      = hit_q;
        free_d     = free_q;
        hit_idx_d  = hit_idx_q;
        free_idx_d = free_idx_q;
        idx_d      = idx_q;
        pend_d     = pend_q | tick;
        used_d     = used_q;
        grp_d      = grp_q;
        tmr_d      = tmr_q;
        count_d    = count_q;
        drop_d     = 1'b0;
        exp_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    type_d  = in_type;
                    group_d = in_group;
                    state_d = MATCH;
                end else if (pend_q) begin
                    // a tick landing in this very cycle must survive the clear
                    pend_d  = tick;
                    idx_d   = '0;
                    state_d = AGE;
                end
            end
            MATCH: begin
                hit_d      = m_hit;
                free_d     = m_free;
                hit_idx_d  = m_hit_idx;
                free_idx_d = m_free_idx;
                state_d    = UPDATE;
            end
            UPDATE: begin
                state_d = IDLE;
                if (is_report(type_q)) begin
                    if (!is_mcast(group_q)) begin
                        drop_d = 1'b1;
                    end else if (hit_q) begin
                        tmr_d[hit_idx_q] = GMI_T;
                    end else if (free_q) begin
                        used_d[free_idx_q] = 1'b1;
                        grp_d[free_idx_q]  = group_q;
                        tmr_d[free_idx_q]  = GMI_T;
                        count_d            = count_q + CW'(1);
                    end else begin
                        drop_d = 1'b1;
                    end
                end else if (type_q == IGMP_LEAVE && hit_q && tmr_q[hit_idx_q] > LMQT_T) begin
                    tmr_d[hit_idx_q] = LMQT_T;
                end
            end
            AGE: begin
                if (used_q[idx_q]) begin
                    tmr_d[idx_q] = tmr_q[idx_q] - TIMER_W'(1);
                    if (tmr_q[idx_q] == TIMER_W'(1)) begin
                        used_d[idx_q] = 1'b0;
                        count_d       = count_q - CW'(1);
                        exp_d         = 1'b1;
                    end
                end
                idx_d   = idx_q + IW'(1);
                state_d = idx_q == IW'(ENTRIES - 1) ? IDLE : AGE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            type_q      <= '0;
            group_q     <= '0;
            hit_q       <= 1'b0;
            free_q      <= 1'b0;
            hit_idx_q   <= '0;
            free_idx_q  <= '0;
            idx_q       <= '0;
            pend_q      <= 1'b0;
            used_q      <= '0;
            count_q     <= '0;
            drop_q      <= 1'b0;
            exp_q       <= 1'b0;
            lkp_valid_q <= 1'b0;
            lkp_hit_q   <= 1'b0;
            for (int i = 0; i < ENTRIES; i++) begin
                grp_q[i] <= '0;
                tmr_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            type_q      <= type_d;
            group_q     <= group_d;
            hit_q       <= hit_d;
            free_q      <= free_d;
            hit_idx_q   <= hit_idx_d;
            free_idx_q  <= free_idx_d;
            idx_q       <= idx_d;
            pend_q      <= pend_d;
            used_q      <= used_d;
            grp_q       <= grp_d;
            tmr_q       <= tmr_d;
            count_q     <= count_d;
            drop_q      <= drop_d;
            exp_q       <= exp_d;
            lkp_valid_q <= lkp_req;
            lkp_hit_q   <= lkp_req & lkp_match;
        end
    end

    assign in_ready     = state_q == IDLE;
    assign lkp_valid    = lkp_valid_q;
    assign lkp_hit      = lkp_hit_q;
    assign count        = count_q;
    assign full         = count_q == CW'(ENTRIES);
    assign drop_pulse   = drop_q;
    assign expire_pulse = exp_q;

`ifdef IGMP_STATS_EN
    logic [15:0] rpt_q, leave_q, query_q, dropc_q;
    logic        upd;

    assign upd = state_q == UPDATE;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rpt_q   <= '0;
            leave_q <= '0;
            query_q <= '0;
            dropc_q <= '0;
        end else begin
            if (upd && is_report(type_q) && rpt_q != 16'hFFFF) rpt_q <= rpt_q + 16'd1;
            if (upd && type_q == IGMP_LEAVE && leave_q != 16'hFFFF) leave_q <= leave_q + 16'd1;
            if (upd && type_q == IGMP_QUERY && query_q != 16'hFFFF) query_q <= query_q + 16'd1;
            if (drop_d && dropc_q != 16'hFFFF) dropc_q <= dropc_q + 16'd1;
        end
    end

    assign rpt_cnt   = rpt_q;
    assign leave_cnt = leave_q;
    assign query_cnt = query_q;
    assign drop_cnt  = dropc_q;
`else
    assign rpt_cnt   = '0;
    assign leave_cnt = '0;
    assign query_cnt = '0;
    assign drop_cnt  = '0;
`endif

endmodule

// File: tb/tb_igmp_group_table.sv
// tb_igmp_group_table: vector table, corner sequences and a random run against a group/timer model.
module tb_igmp_group_table;

    localparam int ENTRIES  = 8;
    localparam int TIMER_W  = 8;
    localparam int GMI      = 6;
    localparam int LMQT     = 2;
    localparam int TICK_DIV = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_type = '0;
    logic [31:0] in_group = '0;
    logic        in_ready;
    logic        lkp_req = 1'b0;
    logic [31:0] lkp_group = '0;
    logic        lkp_valid, lkp_hit;
    logic [3:0]  count;
    logic        full, drop_pulse, expire_pulse;
    logic [15:0] rpt_cnt, leave_cnt, query_cnt, drop_cnt;

    igmp_group_table #(
        .ENTRIES(ENTRIES), .TIMER_W(TIMER_W), .GMI(GMI), .LMQT(LMQT), .TICK_DIV(TICK_DIV)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_type(in_type), .in_group(in_group), .in_ready(in_ready),
        .lkp_req(lkp_req), .lkp_group(lkp_group), .lkp_valid(lkp_valid), .lkp_hit(lkp_hit),
        .count(count), .full(full), .drop_pulse(drop_pulse), .expire_pulse(expire_pulse),
        .rpt_cnt(rpt_cnt), .leave_cnt(leave_cnt), .query_cnt(query_cnt), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc;
    int exp_seen = 0;

    // cycles since reset release; phase cyc%TICK_DIV tracks the aging prescaler
    always @(posedge clk or negedge rst) begin
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    always @(negedge clk) if (rst && expire_pulse) exp_seen++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1);
    end

    // Reference model: group -> remaining ticks
    int         mdl [bit [31:0]];
    int         m_exp;
    int         ticks_applied;

    function automatic void mdl_age();
        bit [31:0] ks[$];
        foreach (mdl[g]) ks.push_back(g);
        foreach (ks[i]) begin
            mdl[ks[i]] = mdl[ks[i]] - 1;
            if (mdl[ks[i]] == 0) begin
                mdl.delete(ks[i]);
                m_exp++;
            end
        end
    endfunction

    // applies one message, returns whether a drop is expected
    function automatic bit mdl_msg(input logic [7:0] t, input logic [31:0] g);
        if (t == 8'h12 || t == 8'h16 || t == 8'h22) begin
            if (g[31:28] != 4'hE) return 1'b1;
            if (mdl.exists(g) || mdl.num() < ENTRIES) begin
                mdl[g] = GMI;
                return 1'b0;
            end
            return 1'b1;
        end
        if (t == 8'h17 && mdl.exists(g) && mdl[g] > LMQT) mdl[g] = LMQT;
        return 1'b0;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // start/end at a negedge; checks busy window and the T+3 commit
    task automatic send_chk(input string nm, input logic [7:0] t, input logic [31:0] g,
                            input logic ed, input int ec);
        int n = 0;
        while (!in_ready && n < 64) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_ready_wait"}, in_ready, 1);
        in_valid = 1'b1;
        in_type  = t;
        in_group = g;
        @(posedge clk);
        #1 in_valid = 1'b0;
        chk({nm, "_busy1"}, in_ready, 0);
        @(posedge clk);
        #1 chk({nm, "_busy2"}, in_ready, 0);
        @(posedge clk);
        #1;
        chk({nm, "_count"}, count, 32'(ec));
        chk({nm, "_drop"}, drop_pulse, ed);
        chk({nm, "_full"}, full, ec == ENTRIES);
        chk({nm, "_ready_back"}, in_ready, 1);
        @(negedge clk);
    endtask

    task automatic lookup(input string nm, input logic [31:0] g, input logic eh);
        lkp_req   = 1'b1;
        lkp_group = g;
        @(posedge clk);
        #1 lkp_req = 1'b0;
        chk({nm, "_lkp_valid"}, lkp_valid, 1);
        chk({nm, "_lkp_hit"}, lkp_hit, eh);
        @(posedge clk);
        #1 chk({nm, "_lkp_valid_drop"}, lkp_valid, 0);
        @(negedge clk);
    endtask

    task automatic wait_window();
        while (!((cyc % TICK_DIV) >= 14 && (cyc % TICK_DIV) <= 22)) @(negedge clk);
    endtask

    typedef struct {
        logic [7:0]  t;
        logic [31:0] g;
        logic        drop;
        int          cnt;
        logic        hit;
    } vec_t;

    vec_t vt[15];
    logic [7:0] rtys[3];
    logic [7:0] tys[8];

    initial begin
        int n;
        logic [7:0]  t;
        logic [31:0] g;
        logic        d;
        int          exp_base;

        rtys = '{8'h12, 8'h16, 8'h22};
        tys  = '{8'h16, 8'h12, 8'h22, 8'h17, 8'h17, 8'h11, 8'h05, 8'h16};
        vt[0] = '{8'h16, 32'hE000_0105, 1'b0, 1, 1'b1};
        for (int i = 1; i < 8; i++) vt[i] = '{rtys[i % 3], 32'hE000_0200 + 32'(i), 1'b0, i + 1, 1'b1};
        vt[8]  = '{8'h16, 32'hE000_0208, 1'b1, 8, 1'b0};
        vt[9]  = '{8'h16, 32'hE000_0105, 1'b0, 8, 1'b1};
        vt[10] = '{8'h16, 32'h0A00_0001, 1'b1, 8, 1'b0};
        vt[11] = '{8'h11, 32'hE000_0301, 1'b0, 8, 1'b0};
        vt[12] = '{8'h05, 32'hE000_0302, 1'b0, 8, 1'b0};
        vt[13] = '{8'h17, 32'hE000_0203, 1'b0, 8, 1'b1};
        vt[14] = '{8'h17, 32'hE000_0999, 1'b0, 8, 1'b0};

        #3 rst = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_count", count, 0);
        chk("rst_full", full, 0);
        chk("rst_lkp_valid", lkp_valid, 0);
        chk("rst_lkp_hit", lkp_hit, 0);
        chk("rst_drop", drop_pulse, 0);
        chk("rst_expire", expire_pulse, 0);
        chk("rst_stats", {rpt_cnt, query_cnt}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // vector table: fill, overflow, refresh, non-multicast, query, unknown, leave
        foreach (vt[i]) begin
            send_chk($sformatf("vec%0d", i), vt[i].t, vt[i].g, vt[i].drop, vt[i].cnt);
            lookup($sformatf("vec%0d", i), vt[i].g, vt[i].hit);
        end

        // leave shortens the timer to LMQT ticks, then the entry ages out
        do_reset();
        send_chk("lv_rpt", 8'h16, 32'hE000_0105, 1'b0, 1);
        send_chk("lv_leave", 8'h17, 32'hE000_0105, 1'b0, 1);
        n = 0;
        while (!expire_pulse && n < 3 * TICK_DIV) begin
            @(negedge clk);
            n++;
        end
        chk("lv_expire_seen", expire_pulse, 1);
        chk("lv_expire_tick", cyc / TICK_DIV, LMQT);
        @(negedge clk);
        chk("lv_expire_once", expire_pulse, 0);
        chk("lv_count", count, 0);
        while (!in_ready) @(negedge clk);
        lookup("lv", 32'hE000_0105, 1'b0);

        // reset while the message sits in UPDATE
        send_chk("rs_pre", 8'h16, 32'hE000_0501, 1'b0, 1);
        while (!in_ready) @(negedge clk);
        in_valid = 1'b1;
        in_type  = 8'h16;
        in_group = 32'hE000_0502;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lkp_req   = 1'b1;
        lkp_group = 32'hE000_0501;
        @(posedge clk);
        #1 lkp_req = 1'b0;
        chk("rs_pre_lkp_hit", lkp_hit, 1);
        #2 rst = 1'b0;
        #1;
        chk("rs_count", count, 0);
        chk("rs_in_ready", in_ready, 1);
        chk("rs_lkp_valid", lkp_valid, 0);
        chk("rs_lkp_hit", lkp_hit, 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        chk("rs_after_count", count, 0);
        lookup("rs_disc", 32'hE000_0502, 1'b0);

        // statistics
        send_chk("st_r1", 8'h16, 32'hE000_0601, 1'b0, 1);
        send_chk("st_r2", 8'h22, 32'hE000_0602, 1'b0, 2);
        send_chk("st_q", 8'h11, 32'hE000_0000, 1'b0, 2);
`ifdef IGMP_STATS_EN
        chk("st_rpt", rpt_cnt, 2);
        chk("st_query", query_cnt, 1);
        chk("st_leave", leave_cnt, 0);
        chk("st_drop", drop_cnt, 0);
`else
        chk("st_rpt_off", rpt_cnt, 0);
        chk("st_query_off", query_cnt, 0);
`endif

        // message accepted in the tick cycle: processed first, AGE right after
        do_reset();
        while (cyc != TICK_DIV - 1) @(negedge clk);
        in_valid = 1'b1;
        in_type  = 8'h16;
        in_group = 32'hE000_0401;
        @(posedge clk);
        #1 in_valid = 1'b0;
        chk("tk_busy", in_ready, 0);
        while (cyc != TICK_DIV + 2) @(negedge clk);
        chk("tk_idle", in_ready, 1);
        chk("tk_count", count, 1);
        @(negedge clk);
        chk("tk_age_start", in_ready, 0);
        while (cyc != TICK_DIV + 10) @(negedge clk);
        chk("tk_age_last", in_ready, 0);
        @(negedge clk);
        chk("tk_age_done", in_ready, 1);

        // held in_valid: busy-cycle group B is not taken until IDLE
        wait_window();
        in_valid = 1'b1;
        in_type  = 8'h16;
        in_group = 32'hE000_0501;
        @(posedge clk);
        #1 in_group = 32'hE000_0502;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 chk("hv_count_a", count, 2);
        chk("hv_ready", in_ready, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 chk("hv_count_b", count, 3);
        @(negedge clk);
        lookup("hv_a", 32'hE000_0501, 1'b1);
        lookup("hv_b", 32'hE000_0502, 1'b1);

        // random run against the model
        do_reset();
        mdl.delete();
        m_exp         = 0;
        ticks_applied = 0;
        exp_base      = exp_seen;
        for (int k = 0; k < 70; k++) begin
            wait_window();
            while (ticks_applied < cyc / TICK_DIV) begin
                mdl_age();
                ticks_applied++;
            end
            t = tys[$urandom_range(0, 7)];
            g = ($urandom_range(0, 11) == 0) ? 32'h0A00_0001 : 32'hE000_0100 + 32'($urandom_range(0, 9));
            d = mdl_msg(t, g);
            send_chk("rnd", t, g, d, mdl.num());
            lookup("rnd", g, mdl.exists(g));
        end
        wait_window();
        while (ticks_applied < cyc / TICK_DIV) begin
            mdl_age();
            ticks_applied++;
        end
        chk("rnd_expires", exp_seen - exp_base, m_exp);
        chk("rnd_final_count", count, mdl.num());

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/igmp_group_table.md
# igmp_group_table

Membership table directly downstream of `receiving_igmp`. Consumes each parsed, checksum-valid IGMP message (type byte and group address), maintains up to ENTRIES active multicast groups with per-group membership timers, ages them on a prescaled tick, and answers single-cycle-latency group lookups for the forwarding path.

## Interface
- ENTRIES, 8: table depth, 2..32.
- TIMER_W, 8: membership timer width.
- GMI, 255: group membership interval loaded on report, in ticks; nonzero.
- LMQT, 2: last-member query time in ticks, applied on leave; nonzero, ≤ GMI.
- TICK_DIV, 1000: clk cycles per aging tick; ≥ 4*ENTRIES.
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  message strobe; driven from upstream `valid`.
- in_type  in  8  IGMP type byte (`typea`).
- in_group  in  32  group address (`groupadd`).
- in_ready  out  1  table can accept a message this cycle.
- lkp_req  in  1  lookup request.
- lkp_group  in  32  address to look up.
- lkp_valid  out  1  lookup result strobe.
- lkp_hit  out  1  address present in table.
- count  out  $clog2(ENTRIES+1)  occupied entries.
- full  out  1  count == ENTRIES.
- drop_pulse  out  1  one-cycle pulse: report rejected.
- expire_pulse  out  1  one-cycle pulse: entry aged out.
- rpt_cnt, leave_cnt, query_cnt, drop_cnt  out  16 each  statistics (see Configuration).

## Operation
- Entry = {used, group[31:0], timer[TIMER_W-1:0]}.
- FSM states: IDLE, MATCH, UPDATE, AGE. in_ready = 1 only in IDLE.
- IDLE: in_valid accepted → capture type/group, go MATCH. Else if tick_pending → clear it, index=0, go AGE.
- MATCH: parallel compare against used entries; register hit (lowest matching index) and free (lowest unused index); go UPDATE.
- UPDATE, by type:
  - 0x12/0x16/0x22 report: group outside 224.0.0.0/4 → drop_pulse. Hit → timer=GMI. Miss with free → allocate, timer=GMI, count+1. Miss, no free → drop_pulse, table unchanged.
  - 0x17 leave: hit → timer=min(timer, LMQT); miss → no action.
  - 0x11 query: no table change.
  - Any other type: ignored, not counted.
  - → IDLE.
- AGE: one entry per cycle, index 0..ENTRIES-1. Used entry: timer decrements; timer reaching 0 → used=0, count−1, expire_pulse. Last index → IDLE.
- Tick: igmp_tick_gen pulses every TICK_DIV cycles and sets sticky tick_pending; a tick arriving while pending is already set merges.
- Accepted message takes priority over pending tick in IDLE.
- Lookup is independent of FSM: compares lkp_group against table state at the request cycle.

## Timing
- Reset: all entries unused, count=0, full=0, lkp_valid=0, lkp_hit=0, drop/expire pulses 0, counters 0, tick_pending=0, prescaler 0, state IDLE, in_ready=1.
- Message accepted at cycle T → in_ready low T+1, T+2; table/count updated at T+3 edge; in_ready high again at T+3.
- lkp_req at T → lkp_valid, lkp_hit at T+1; lookup at T does not see an update committing in the same cycle.
- AGE occupies ENTRIES cycles; in_ready low throughout.
- in_valid while in_ready=0: ignored (upstream holds or drops); not counted.
- Reset asserted mid-operation: immediate return to reset state; captured message discarded.

## Configuration
- IGMP_STATS_EN defined: rpt_cnt, leave_cnt, query_cnt, drop_cnt increment in UPDATE per classified message; 16-bit saturating at 0xFFFF.
- Not defined: counter logic absent; the four ports are driven constant 0.

## Structure
- Package `igmp_pkg`: type constants IGMP_QUERY=8'h11, IGMP_V1_REPORT=8'h12, IGMP_V2_REPORT=8'h16, IGMP_V3_REPORT=8'h22, IGMP_LEAVE=8'h17; FSM state enum; 224.0.0.0/4 mask constant.
- Sub-module `igmp_tick_gen`: TICK_DIV prescaler, single-cycle tick output, shares clk/rst.

## Test plan
- Report 0x16 group 0xE0000105 → count 1 at T+3; lookup 0xE0000105 → lkp_hit=1 next cycle.
- Fill 8 distinct reports, send 9th new group → drop_pulse, count stays 8, full=1; refresh of an existing group → no drop.
- Report then leave 0x17 same group, TICK_DIV=32 → expire_pulse after 2 ticks, count 0, lkp_hit=0.
- Report 0x16 group 0x0A000001 (non-multicast) → drop_pulse, count 0.
- in_valid coinciding with tick → message processed first, AGE follows immediately; held in_valid during busy cycles accepted only once in_ready=1.
- Reset asserted during UPDATE → all outputs at reset values; with IGMP_STATS_EN, 2 reports + 1 query → rpt_cnt=2, query_cnt=1.
